// File: rtl/corr_pkg.sv
// ---------------------------------------------------------------------------
// corr_pkg
// Definitions shared by the correlation BRAM writer, the correlator core and
// the BRAM wrapper:
//   ROW_W      pixels per row, equal to the BRAM word width
//   ROWS       rows per frame, equal to the number of words per frame buffer
//   ADDR_W     BRAM address width: one buffer-select bit plus the row index
//   wr_state_t writer FSM states
// ---------------------------------------------------------------------------
package corr_pkg;

  localparam int ROW_W  = 128;
  localparam int ROWS   = 256;
  localparam int ADDR_W = 9;

  typedef enum logic [0:0] {
    WAIT_SOF = 1'b0,
    FILL     = 1'b1
  } wr_state_t;

endpackage : corr_pkg

// File: rtl/frame_bram_writer.sv
// ---------------------------------------------------------------------------
// frame_bram_writer
// Packs a raster stream of 1-bit pixels into ROW_W-bit rows and writes each
// completed row into one half of the dual-frame correlation BRAM. The writer
// fills the buffer the correlator is not reading. When a frame completes, it
// publishes that buffer through frame_sel and moves to the other buffer.
//
// Ports:
//   clk        block clock
//   resetn     asynchronous active-low reset
//   pix_valid  pix_bit / pix_sof are valid this cycle
//   pix_bit    binarised pixel value
//   pix_sof    first pixel of a frame (qualified by pix_valid)
//   bram_addr  write address {buffer select, row}
//   bram_din   packed row; bit 0 is the leftmost pixel
//   bram_we    one-cycle write strobe per completed row
//   frame_sel  buffer holding the last complete frame
//   frame_done one-cycle pulse alongside the final write of a frame
//   sync_err   sticky flag: pix_sof seen mid-frame (cleared only by reset)
// ---------------------------------------------------------------------------
module frame_bram_writer #(
  parameter int ROW_W  = corr_pkg::ROW_W,
  parameter int ROWS   = corr_pkg::ROWS,
  parameter int ADDR_W = corr_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              pix_valid,
  input  logic              pix_bit,
  input  logic              pix_sof,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [ROW_W-1:0]  bram_din,
  output logic              bram_we,
  output logic              frame_sel,
  output logic              frame_done,
  output logic              sync_err
);

  import corr_pkg::*;

  localparam int X_W = (ROW_W > 1) ? $clog2(ROW_W) : 1;
  localparam int R_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [X_W-1:0] X_LAST = X_W'(ROW_W - 1);
  localparam logic [R_W-1:0] R_LAST = R_W'(ROWS - 1);

  wr_state_t           state_q,      state_d;
  logic [X_W-1:0]      x_q,          x_d;
  logic [R_W-1:0]      row_q,        row_d;
  logic [ROW_W-1:0]    pack_q,       pack_d;
  logic                bram_we_q,    bram_we_d;
  logic [ADDR_W-1:0]   bram_addr_q,  bram_addr_d;
  logic [ROW_W-1:0]    bram_din_q,   bram_din_d;
  logic                frame_sel_q,  frame_sel_d;
  logic                frame_done_q, frame_done_d;
  logic                sync_err_q,   sync_err_d;

  // Position the accepted pixel lands on. This normally equals (x_q, row_q),
  // but a restarting pix_sof forces it to (0,0).
  logic                accept_s;
  logic [X_W-1:0]      x_acc_s;
  logic [R_W-1:0]      row_acc_s;
  logic [ROW_W-1:0]    row_word_s;

  // Next-state logic: pixel acceptance, packing, row writes and frame handover
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    row_d        = row_q;
    pack_d       = pack_q;
    bram_we_d    = 1'b0;
    bram_addr_d  = bram_addr_q;
    bram_din_d   = bram_din_q;
    frame_sel_d  = frame_sel_q;
    frame_done_d = 1'b0;
    sync_err_d   = sync_err_q;
    accept_s     = 1'b0;
    x_acc_s      = x_q;
    row_acc_s    = row_q;

    case (state_q)
      WAIT_SOF: begin
        if (pix_valid && pix_sof) begin
          accept_s  = 1'b1;
          x_acc_s   = '0;
          row_acc_s = '0;
        end else begin
          accept_s  = 1'b0;
        end
      end
      FILL: begin
        if (pix_valid) begin
          accept_s = 1'b1;
          // SOF anywhere except (0,0) abandons the partial frame. The restart
          // stays in the same buffer, so frame_sel is untouched.
          if (pix_sof && ((x_q != X_W'(0)) || (row_q != R_W'(0)))) begin
            sync_err_d = 1'b1;
            x_acc_s    = '0;
            row_acc_s  = '0;
          end else begin
            x_acc_s    = x_q;
            row_acc_s  = row_q;
          end
        end else begin
          accept_s = 1'b0;
        end
      end
      default: begin
        state_d = WAIT_SOF;
      end
    endcase

    row_word_s          = pack_q;
    row_word_s[x_acc_s] = pix_bit;

    if (accept_s) begin
      pack_d = row_word_s;
      if (x_acc_s == X_LAST) begin
        // The completed row goes to bram_din. The packing register is then
        // free for the next row's first pixel in the following cycle.
        bram_we_d   = 1'b1;
        bram_din_d  = row_word_s;
        bram_addr_d = ADDR_W'({~frame_sel_q, row_acc_s});
        x_d         = '0;
        if (row_acc_s == R_LAST) begin
          frame_done_d = 1'b1;
          frame_sel_d  = ~frame_sel_q;
          row_d        = '0;
          state_d      = WAIT_SOF;
        end else begin
          row_d        = row_acc_s + R_W'(1);
          state_d      = FILL;
        end
      end else begin
        x_d     = x_acc_s + X_W'(1);
        row_d   = row_acc_s;
        state_d = FILL;
      end
    end else begin
      pack_d = pack_q;
    end
  end

  // State, counters, packing register and registered BRAM/status outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= WAIT_SOF;
      x_q          <= '0;
      row_q        <= '0;
      pack_q       <= '0;
      bram_we_q    <= 1'b0;
      bram_addr_q  <= '0;
      bram_din_q   <= '0;
      frame_sel_q  <= 1'b1;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      row_q        <= row_d;
      pack_q       <= pack_d;
      bram_we_q    <= bram_we_d;
      bram_addr_q  <= bram_addr_d;
      bram_din_q   <= bram_din_d;
      frame_sel_q  <= frame_sel_d;
      frame_done_q <= frame_done_d;
      sync_err_q   <= sync_err_d;
    end
  end

  assign bram_we    = bram_we_q;
  assign bram_addr  = bram_addr_q;
  assign bram_din   = bram_din_q;
  assign frame_sel  = frame_sel_q;
  assign frame_done = frame_done_q;
  assign sync_err   = sync_err_q;

endmodule : frame_bram_writer
